instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, bytecode ROM address width.
REQ-002 The block SHALL have parameter WORD_W, default 17, stack word / immediate width.
REQ-003 The block SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have port rom_addr, output, ADDR_W, byte address to bytecode ROM.
REQ-006 The block SHALL have port rom_data, input, 8, ROM byte, valid one cycle after rom_addr.
REQ-007 The block SHALL have port op_valid, output, 1, decoded instruction available to the execute stage.
REQ-008 The block SHALL have port op_ready, input, 1, the execute stage accepts the instruction.
REQ-009 The block SHALL have port op_code, output, 8, opcode byte.
REQ-010 The block SHALL have port op_imm, output, WORD_W, PUSH immediate, zero-extended; 0 for non-PUSH.
REQ-011 The block SHALL have port op_pc, output, ADDR_W, address of the opcode byte.
REQ-012 The block SHALL have port op_illegal, output, 1, opcode in 0x62..0x7F (PUSH3..PUSH32, unsupported).
REQ-013 The block SHALL have port redir_valid, input, 1, taken-JUMPI redirect from execute.
REQ-014 The block SHALL have port redir_pc, input, ADDR_W, redirect target.
REQ-015 The block SHALL have port halted, output, 1, a STOP was accepted.

Function
REQ-016 The FSM SHALL have states OP_ADDR, OP_DATA, IMM_DATA, HOLD, HALT.
REQ-017 OP_ADDR SHALL drive rom_addr=pc and go to OP_DATA.
REQ-018 OP_DATA SHALL latch rom_data into op_code and op_pc=pc. PUSH1 (0x60) SHALL set remaining=1 and PUSH2 (0x61) SHALL set remaining=2, each driving rom_addr=pc+1 and going to IMM_DATA. Every other opcode SHALL go to HOLD with op_imm=0.
REQ-019 IMM_DATA SHALL shift each byte in big-endian (op_imm = op_imm<<8 | byte), fetching the next byte at the following address until remaining=0, then go to HOLD.
REQ-020 In HOLD, op_valid=1 and op_code/op_imm/op_pc/op_illegal SHALL be stable until op_ready.
REQ-021 On the HOLD handshake, pc SHALL become op_pc+1+imm_len (imm_len = 0, 1 or 2). The same cycle SHALL drive rom_addr=new pc and go to OP_DATA, or to HALT if op_code=0x00.
REQ-022 Latency SHALL be: with op_ready held high, a plain opcode issues every 2 cycles, PUSH1 every 3, PUSH2 every 4. The first op_valid SHALL occur 2 cycles after rst deasserts.
REQ-023 In HALT, op_valid SHALL be 0 and halted SHALL be 1, and rom_addr SHALL hold its last value.
REQ-024 pc and immediate addresses SHALL wrap modulo 2^ADDR_W, so an immediate at 1023 continues at 0.
REQ-025 redir_valid SHALL take priority over all other events in every state, including HALT and a simultaneous op_ready. On redirect, the held instruction and any in-flight byte SHALL be discarded, op_valid SHALL drop next cycle, halted SHALL clear, pc SHALL become redir_pc, and fetch SHALL restart in OP_ADDR.
REQ-026 op_valid SHALL never be asserted in the cycle after redir_valid.
REQ-027 op_illegal opcodes SHALL be issued with op_imm=0 and imm_len=0. Execute decides to halt.

Reset
REQ-028 While rst is high, the FSM SHALL be OP_ADDR, pc=0, rom_addr=0, op_valid=0, op_code=0, op_imm=0, op_pc=0, op_illegal=0, halted=0.
REQ-029 rst SHALL override redir_valid and any in-progress immediate assembly.

Structure
REQ-030 Opcode constants (STOP 0x00, PUSH0 0x5F, PUSH1 0x60, PUSH2 0x61, the PUSH3..PUSH32 range), ADDR_W and WORD_W defaults, and the FSM state type SHALL live in the shared em opcode package/header used by the processor.
REQ-031 The block SHALL be a single module with no sub-module.

Verification
REQ-032 ROM 5F 01 00 with op_ready=1 SHALL issue (5F,pc0,imm0) in cycle 2, (01,pc1) in cycle 4, and (00,pc2) in cycle 6, then halted=1 and op_valid=0.
REQ-033 ROM 61 12 34 00 SHALL issue op_code=61, op_imm=0x01234, op_pc=0, then 00 at op_pc=3.
REQ-034 With op_ready=0 for 5 cycles on PUSH1 0xAB, all outputs SHALL stay stable. Accept SHALL come on the 6th cycle, and the next op_pc SHALL be 2.
REQ-035 redir_valid with redir_pc=0x010 during IMM_DATA of a PUSH2 SHALL drop the partial op, and the next issued op_pc SHALL be 0x010. The same SHALL hold when redir_valid is asserted while halted, with halted clearing.
REQ-036 PUSH2 at address 1022 with bytes at 1023 and 0 SHALL give the correct immediate and a next pc of 1.
REQ-037 Opcode 0x7F SHALL issue with op_illegal=1 and op_imm=0, and rst asserted mid-PUSH2 SHALL give reset values next cycle.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Opcode constants, default widths and the fetch FSM state type for instr_fetch.
package instr_fetch_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int WORD_W_DEF = 17;

    localparam logic [7:0] OP_STOP        = 8'h00;
    localparam logic [7:0] OP_PUSH0       = 8'h5F;
    localparam logic [7:0] OP_PUSH1       = 8'h60;
    localparam logic [7:0] OP_PUSH2       = 8'h61;
    localparam logic [7:0] OP_PUSH_ILL_LO = 8'h62;
    localparam logic [7:0] OP_PUSH_ILL_HI = 8'h7F;

    typedef enum logic [2:0] {
        OP_ADDR,
        OP_DATA,
        IMM_DATA,
        HOLD,
        HALT
    } fetch_state_t;

    // Immediate bytes following the opcode; unsupported wide pushes carry none.
    function automatic logic [1:0] imm_len(input logic [7:0] op);
        case (op)
            OP_PUSH1: return 2'd1;
            OP_PUSH2: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [7:0] op);
        return (op >= OP_PUSH_ILL_LO) && (op <= OP_PUSH_ILL_HI);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: ROM port, decoded-op handshake to execute, redirect and halt status.
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF
);
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              op_valid;
    logic              op_ready;
    logic [7:0]        op_code;
    logic [WORD_W-1:0] op_imm;
    logic [ADDR_W-1:0] op_pc;
    logic              op_illegal;
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_pc;
    logic              halted;

    modport master (
        output rom_addr, input rom_data,
        output op_valid, input op_ready,
        output op_code, output op_imm, output op_pc, output op_illegal,
        input  redir_valid, input redir_pc,
        output halted
    );

    modport slave (
        input  rom_addr, output rom_data,
        input  op_valid, output op_ready,
        input  op_code, input op_imm, input op_pc, input op_illegal,
        output redir_valid, output redir_pc,
        input  halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Bytecode fetch/decode: reads opcode plus up to two PUSH immediate bytes from a 1-cycle ROM.
// Latency: first op 2 cycles after reset; plain op every 2 cycles, PUSH1 every 3, PUSH2 every 4.
// Backpressure: op held stable in HOLD until op_ready; redir_valid preempts everything.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master fif
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_c;
    logic [1:0]        remaining;
    logic [7:0]        op_code_q;
    logic [WORD_W-1:0] op_imm_q;
    logic [ADDR_W-1:0] op_pc_q;
    logic              op_ill_q;
    logic [ADDR_W-1:0] next_pc;

    assign next_pc = op_pc_q + ADDR_W'(1) + ADDR_W'(imm_len(op_code_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= OP_ADDR;
            pc         <= '0;
            rom_addr_q <= '0;
            remaining  <= '0;
            op_code_q  <= '0;
            op_imm_q   <= '0;
            op_pc_q    <= '0;
            op_ill_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            rom_addr_q <= rom_addr_c;
            if (fif.redir_valid) begin
                pc        <= fif.redir_pc;
                remaining <= '0;
            end else begin
                case (state)
                    OP_DATA: begin
                        op_code_q <= fif.rom_data;
                        op_pc_q   <= pc;
                        op_ill_q  <= is_illegal(fif.rom_data);
                        op_imm_q  <= '0;
                        remaining <= imm_len(fif.rom_data);
                        if (imm_len(fif.rom_data) != 2'd0)
                            pc <= pc + ADDR_W'(1);
                    end
                    IMM_DATA: begin
                        op_imm_q  <= {op_imm_q[WORD_W-9:0], fif.rom_data};
                        remaining <= remaining - 2'd1;
                        if (remaining == 2'd2)
                            pc <= pc + ADDR_W'(1);
                    end
                    HOLD: begin
                        if (fif.op_ready)
                            pc <= next_pc;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (fif.redir_valid) begin
            state_nxt = OP_ADDR;
        end else begin
            case (state)
                OP_ADDR:  state_nxt = OP_DATA;
                OP_DATA:  state_nxt = (imm_len(fif.rom_data) != 2'd0) ? IMM_DATA : HOLD;
                IMM_DATA: state_nxt = (remaining == 2'd1) ? HOLD : IMM_DATA;
                HOLD: begin
                    if (fif.op_ready)
                        state_nxt = (op_code_q == OP_STOP) ? HALT : OP_DATA;
                end
                HALT:     state_nxt = HALT;
                default:  state_nxt = OP_ADDR;
            endcase
        end
    end

    // ROM address is combinational so the next byte is requested in the same cycle as the decision.
    always_comb begin
        rom_addr_c = rom_addr_q;
        if (rst) begin
            rom_addr_c = '0;
        end else if (!fif.redir_valid) begin
            case (state)
                OP_ADDR:  rom_addr_c = pc;
                OP_DATA:  if (imm_len(fif.rom_data) != 2'd0) rom_addr_c = pc + ADDR_W'(1);
                IMM_DATA: if (remaining == 2'd2) rom_addr_c = pc + ADDR_W'(1);
                HOLD:     if (fif.op_ready) rom_addr_c = next_pc;
                default:  ;
            endcase
        end
    end

    assign fif.rom_addr   = rom_addr_c;
    assign fif.op_valid   = !rst && (state == HOLD);
    assign fif.halted     = !rst && (state == HALT);
    assign fif.op_code    = op_code_q;
    assign fif.op_imm     = op_imm_q;
    assign fif.op_pc      = op_pc_q;
    assign fif.op_illegal = op_ill_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected ops come from walking the ROM image in plain arithmetic.
module tb_instr_fetch;

    localparam int AW = 10;
    localparam int WW = 17;
    localparam int MEM_SZ = 1 << AW;

    typedef struct {
        int op;
        int imm;
        int pc;
        bit ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] mem [MEM_SZ];
    exp_t exp_q [$];
    int   hs_cyc [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t0 = 0;

    instr_fetch_if #(.ADDR_W(AW), .WORD_W(WW)) fif ();

    instr_fetch #(.ADDR_W(AW), .WORD_W(WW)) dut (
        .clk (clk),
        .rst (rst),
        .fif (fif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) fif.rom_data <= mem[fif.rom_addr];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference: linear walk of the program image from start until a STOP.
    task automatic push_walk(input int start);
        int p, op, len, imm;
        exp_t e;
        exp_q.delete();
        p = start % MEM_SZ;
        for (int k = 0; k < 2000; k++) begin
            op  = mem[p];
            len = (op == 'h60) ? 1 : (op == 'h61) ? 2 : 0;
            imm = 0;
            for (int j = 1; j <= len; j++) imm = imm * 256 + mem[(p + j) % MEM_SZ];
            e.op = op; e.imm = imm; e.pc = p; e.ill = (op >= 'h62 && op <= 'h7F);
            exp_q.push_back(e);
            if (op == 0) break;
            p = (p + 1 + len) % MEM_SZ;
        end
    endtask

    // Monitor: compares each accepted op against the scoreboard and watches hold/halt/redirect rules.
    bit         exp_halted = 0, prev_redir = 0, prev_stall = 0;
    logic [7:0] s_code;
    logic [WW-1:0] s_imm;
    logic [AW-1:0] s_pc;
    logic       s_ill;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_halted = 0; prev_redir = 0; prev_stall = 0;
        end else begin
            chk("halted", fif.halted, exp_halted);
            if (exp_halted) chk("valid_in_halt", fif.op_valid, 0);
            if (prev_redir) chk("valid_after_redir", fif.op_valid, 0);
            if (prev_stall) chk("hold_stable", {fif.op_valid, fif.op_code, fif.op_imm, fif.op_pc, fif.op_illegal},
                                {1'b1, s_code, s_imm, s_pc, s_ill});
            if (fif.redir_valid) begin
                exp_halted = 0;
            end else if (fif.op_valid && fif.op_ready) begin
                hs_cyc.push_back(cyc - t0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_op_pc", fif.op_pc, {AW{1'b1}} + 1'b1);
                end else begin
                    e = exp_q.pop_front();
                    chk("op_code", fif.op_code, e.op);
                    chk("op_imm", fif.op_imm, e.imm);
                    chk("op_pc", fif.op_pc, e.pc);
                    chk("op_illegal", fif.op_illegal, e.ill);
                    exp_halted = (e.op == 0);
                end
            end
            prev_redir = fif.redir_valid;
            prev_stall = fif.op_valid && !fif.op_ready && !fif.redir_valid;
            s_code = fif.op_code; s_imm = fif.op_imm; s_pc = fif.op_pc; s_ill = fif.op_illegal;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < MEM_SZ; a++) mem[a] = 8'h00;
    endtask

    task automatic do_reset(input bit with_redir);
        rst = 1'b1;
        fif.redir_valid = with_redir;
        fif.redir_pc = 10'h055;
        tick(1);
        @(negedge clk);
        chk("rst_valid_halted", {fif.op_valid, fif.halted}, 0);
        chk("rst_rom_addr", fif.rom_addr, 0);
        chk("rst_op_fields", {fif.op_code, fif.op_imm, fif.op_pc, fif.op_illegal}, 0);
        tick(1);
        hs_cyc.delete();
        push_walk(0);
        fif.redir_valid = 1'b0;
        rst = 1'b0;
        t0 = cyc;
    endtask

    task automatic redirect(input int a);
        fif.redir_valid = 1'b1;
        fif.redir_pc = AW'(a);
        push_walk(a);
        tick(1);
        fif.redir_valid = 1'b0;
    endtask

    task automatic wait_halted(input string nm);
        for (int i = 0; i < 200; i++) begin
            if (fif.halted) break;
            tick(1);
        end
        chk(nm, fif.halted, 1);
        tick(3);
        chk({nm, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, b;
        fif.op_ready = 1'b0;
        fif.redir_valid = 1'b0;
        fif.redir_pc = '0;
        clear_mem();
        tick(1);

        // 5F 01 00 with ready high: issues at cycles 2, 4, 6 then halts.
        mem[0] = 8'h5F; mem[1] = 8'h01; mem[2] = 8'h00;
        fif.op_ready = 1'b1;
        do_reset(0);
        wait_halted("t_plain_halt");
        chk("t_plain_n", hs_cyc.size(), 3);
        chk("t_plain_c0", hs_cyc[0], 2);
        chk("t_plain_c1", hs_cyc[1], 4);
        chk("t_plain_c2", hs_cyc[2], 6);

        // PUSH2 0x1234 then STOP.
        clear_mem();
        mem[0] = 8'h61; mem[1] = 8'h12; mem[2] = 8'h34; mem[3] = 8'h00;
        do_reset(0);
        wait_halted("t_push2_halt");
        chk("t_push2_c0", hs_cyc[0], 4);
        chk("t_push2_c1", hs_cyc[1], 6);

        // Back-to-back PUSH1: issue every 3 cycles.
        clear_mem();
        mem[0] = 8'h60; mem[1] = 8'hAB; mem[2] = 8'h60; mem[3] = 8'hCD; mem[4] = 8'h00;
        do_reset(0);
        wait_halted("t_push1_halt");
        chk("t_push1_c0", hs_cyc[0], 3);
        chk("t_push1_c1", hs_cyc[1], 6);
        chk("t_push1_c2", hs_cyc[2], 8);

        // Five stalled cycles on PUSH1 0xAB, accept on the sixth.
        clear_mem();
        mem[0] = 8'h60; mem[1] = 8'hAB; mem[2] = 8'h01; mem[3] = 8'h00;
        fif.op_ready = 1'b0;
        do_reset(0);
        tick(8);
        fif.op_ready = 1'b1;
        wait_halted("t_stall_halt");
        chk("t_stall_c0", hs_cyc[0], 8);

        // Redirect during PUSH2 immediate fetch, then again while halted.
        clear_mem();
        mem[0] = 8'h61; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h00;
        mem[16] = 8'h01; mem[17] = 8'h00;
        do_reset(0);
        tick(2);
        redirect(16);
        wait_halted("t_redir_halt");
        chk("t_redir_c0", hs_cyc[0], 5);
        redirect(16);
        chk("t_redir_halt_clear", fif.halted, 0);
        wait_halted("t_redir2_halt");

        // PUSH2 straddling the top of the address space.
        clear_mem();
        mem[1022] = 8'h61; mem[1023] = 8'hBE; mem[0] = 8'hEF; mem[1] = 8'h00;
        do_reset(0);
        redirect(1022);
        wait_halted("t_wrap_halt");

        // Unsupported wide push, then reset (with a competing redirect) mid-PUSH2.
        clear_mem();
        mem[0] = 8'h7F; mem[1] = 8'h00;
        do_reset(0);
        wait_halted("t_illegal_halt");
        mem[0] = 8'h61; mem[1] = 8'h12; mem[2] = 8'h34; mem[3] = 8'h00;
        do_reset(0);
        tick(2);
        do_reset(1);
        wait_halted("t_rst_mid_halt");

        // Randomised programs with random backpressure and redirects.
        for (int round = 0; round < 6; round++) begin
            for (int a = 0; a < MEM_SZ; a++) begin
                r = $urandom_range(0, 99);
                if (r < 3)       mem[a] = 8'h00;
                else if (r < 13) mem[a] = 8'h60;
                else if (r < 23) mem[a] = 8'h61;
                else if (r < 27) mem[a] = 8'($urandom_range(8'h62, 8'h7F));
                else begin
                    b = $urandom_range(1, 255);
                    if (b >= 'h60 && b <= 'h7F) b = 1;
                    mem[a] = 8'(b);
                end
            end
            do_reset(0);
            for (int i = 0; i < 500; i++) begin
                fif.op_ready = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 99) < 2) begin
                    fif.redir_valid = 1'b1;
                    fif.redir_pc = AW'($urandom_range(0, MEM_SZ - 1));
                    push_walk(int'(fif.redir_pc));
                end else begin
                    fif.redir_valid = 1'b0;
                end
                tick(1);
            end
            fif.redir_valid = 1'b0;
            fif.op_ready = 1'b1;
            tick(5);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
